// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage.
//   DATA_W / REG_ADDR_W : default datapath and register-address widths
//   ALUOP_* / FN_*      : ALUOp class and R-type funct encodings
//   alu_op_e            : decoded ALU operation
//   mul_state_e         : iterative multiplier states
//   alu_decode()        : ALUOp/funct -> alu_op_e (mul_en gates the mul funct)
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI, ALU_SLL, ALU_MUL, ALU_NONE
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  function automatic alu_op_e alu_decode(input logic [2:0] aluop,
                                         input logic [5:0] funct,
                                         input logic       mul_en);
    alu_op_e op;
    op = ALU_NONE;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_AND: op = ALU_AND;
      ALUOP_OR:  op = ALU_OR;
      ALUOP_SLT: op = ALU_SLT;
      ALUOP_LUI: op = ALU_LUI;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          FN_SLL:  op = ALU_SLL;
          FN_MUL:  op = mul_en ? ALU_MUL : ALU_NONE;
          default: op = ALU_NONE;
        endcase
      end
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction
endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier, BITS multiplier bits retired per cycle.
//   start   : accepted only in IDLE; captures a and b
//   busy    : high for the N = DATA_W/BITS shift-add cycles
//   done    : high for the single cycle after the last step
//   product : low DATA_W bits of a*b, valid while done
module ex_iter_mul import mips_pkg::*; #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int BITS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int N     = DATA_W / BITS;
  localparam int CNT_W = $clog2(N + 1);

  mul_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand, mplier, acc, partial;

  // Sum of the BITS partial products selected by the low multiplier bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS; i++)
      if (mplier[i]) partial = partial + (mcand << i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= a;
          mplier <= b;
          acc    <= '0;
          cnt    <= CNT_W'(N);
          state  <= BUSY;
        end
        BUSY: begin
          acc    <= acc + partial;
          mcand  <= mcand << BITS;
          mplier <= mplier >> BITS;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign done    = (state == DONE);
  assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU decode, ALU, destination mux and the
// EX/MEM pipeline register. With EX_MULT_EN defined, funct 0x18 runs on an
// iterative multiplier that holds the front end via stall_o; otherwise mul is
// an unlisted funct (result 0) and stall_o is tied low.
// Inputs : ID/EX control (RegWrite..ALUSrc, ALUOp), operands ReadData1/2,
//          SignEx (funct = SignEx[5:0]), rs_addr/In2016/IN1511 register fields,
//          EX/MEM and MEM/WB forwarding write-enable, rd and data.
// Outputs: stall_o, registered *OUT control/data to the MEM stage.
module ex_stage import mips_pkg::*; #(
  parameter int DATA_W             = mips_pkg::DATA_W,
  parameter int REG_ADDR_W         = mips_pkg::REG_ADDR_W,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic                  MemToReg,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  RegDst,
  input  logic                  ALUSrc,
  input  logic [2:0]            ALUOp,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2,
  input  logic [DATA_W-1:0]     SignEx,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] In2016,
  input  logic [REG_ADDR_W-1:0] IN1511,
  input  logic                  exmem_fwd_regwrite,
  input  logic                  memwb_fwd_regwrite,
  input  logic [REG_ADDR_W-1:0] exmem_fwd_rd,
  input  logic [REG_ADDR_W-1:0] memwb_fwd_rd,
  input  logic [DATA_W-1:0]     exmem_fwd_data,
  input  logic [DATA_W-1:0]     memwb_fwd_data,
  output logic                  stall_o,
  output logic                  RegWriteOUT,
  output logic                  MemToRegOUT,
  output logic                  MemReadOUT,
  output logic                  MemWriteOUT,
  output logic [DATA_W-1:0]     ALUResultOUT,
  output logic [DATA_W-1:0]     WriteDataOUT,
  output logic [REG_ADDR_W-1:0] DestRegOUT
);
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, product;
  logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  alu_op_e           op;

  // Register 0 is never forwarded; the younger EX/MEM producer wins.
  assign ex_hit_a = exmem_fwd_regwrite && (exmem_fwd_rd != '0) && (exmem_fwd_rd == rs_addr);
  assign ex_hit_b = exmem_fwd_regwrite && (exmem_fwd_rd != '0) && (exmem_fwd_rd == In2016);
  assign wb_hit_a = memwb_fwd_regwrite && (memwb_fwd_rd != '0) && (memwb_fwd_rd == rs_addr);
  assign wb_hit_b = memwb_fwd_regwrite && (memwb_fwd_rd != '0) && (memwb_fwd_rd == In2016);

  assign fwd_a = ex_hit_a ? exmem_fwd_data : wb_hit_a ? memwb_fwd_data : ReadData1;
  assign fwd_b = ex_hit_b ? exmem_fwd_data : wb_hit_b ? memwb_fwd_data : ReadData2;
  assign alu_b = ALUSrc ? SignEx : fwd_b;

`ifdef EX_MULT_EN
  logic is_mul, mul_busy, mul_done;

  assign op     = alu_decode(ALUOp, SignEx[5:0], 1'b1);
  assign is_mul = (op == ALU_MUL);
  // Stall from the cycle the mul is first seen until the DONE cycle, where
  // ID/EX still holds the mul and its result is written into EX/MEM.
  assign stall_o = ~rst & (mul_busy | (is_mul & ~mul_done));

  ex_iter_mul #(.DATA_W(DATA_W), .BITS(MUL_BITS_PER_CYCLE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (is_mul & ~mul_busy & ~mul_done),
    .a       (fwd_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );
`else
  assign op      = alu_decode(ALUOp, SignEx[5:0], 1'b0);
  assign stall_o = 1'b0;
  assign product = '0;
`endif

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD: alu_res = fwd_a + alu_b;
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_LUI: alu_res = SignEx << 16;
      ALU_SLL: alu_res = alu_b << SignEx[10:6];
      ALU_MUL: alu_res = product;
      default: alu_res = '0;
    endcase
  end

  // EX/MEM register; a stall cycle inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteOUT  <= 1'b0;
      MemToRegOUT  <= 1'b0;
      MemReadOUT   <= 1'b0;
      MemWriteOUT  <= 1'b0;
      ALUResultOUT <= '0;
      WriteDataOUT <= '0;
      DestRegOUT   <= '0;
    end else if (stall_o) begin
      RegWriteOUT  <= 1'b0;
      MemToRegOUT  <= 1'b0;
      MemReadOUT   <= 1'b0;
      MemWriteOUT  <= 1'b0;
      ALUResultOUT <= '0;
      WriteDataOUT <= '0;
      DestRegOUT   <= '0;
    end else begin
      RegWriteOUT  <= RegWrite;
      MemToRegOUT  <= MemToReg;
      MemReadOUT   <= MemRead;
      MemWriteOUT  <= MemWrite;
      ALUResultOUT <= alu_res;
      WriteDataOUT <= fwd_b;
      DestRegOUT   <= RegDst ? IN1511 : In2016;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage. Multiplier scenarios run when EX_MULT_EN is
// defined; otherwise the bench checks that mul is an unlisted single-cycle op.
module tb_ex_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        RegWrite, MemToReg, MemRead, MemWrite, RegDst, ALUSrc;
  logic [2:0]  ALUOp;
  logic [31:0] ReadData1, ReadData2, SignEx;
  logic [4:0]  rs_addr, In2016, IN1511;
  logic        exmem_fwd_regwrite, memwb_fwd_regwrite;
  logic [4:0]  exmem_fwd_rd, memwb_fwd_rd;
  logic [31:0] exmem_fwd_data, memwb_fwd_data;
  logic        stall_o, RegWriteOUT, MemToRegOUT, MemReadOUT, MemWriteOUT;
  logic [31:0] ALUResultOUT, WriteDataOUT;
  logic [4:0]  DestRegOUT;

  int passed = 0, total = 0;
  int stalls, bad;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .SignEx(SignEx),
    .rs_addr(rs_addr), .In2016(In2016), .IN1511(IN1511),
    .exmem_fwd_regwrite(exmem_fwd_regwrite), .memwb_fwd_regwrite(memwb_fwd_regwrite),
    .exmem_fwd_rd(exmem_fwd_rd), .memwb_fwd_rd(memwb_fwd_rd),
    .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
    .stall_o(stall_o), .RegWriteOUT(RegWriteOUT), .MemToRegOUT(MemToRegOUT),
    .MemReadOUT(MemReadOUT), .MemWriteOUT(MemWriteOUT),
    .ALUResultOUT(ALUResultOUT), .WriteDataOUT(WriteDataOUT), .DestRegOUT(DestRegOUT)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    RegWrite = 0; MemToReg = 0; MemRead = 0; MemWrite = 0; RegDst = 0; ALUSrc = 0;
    ALUOp = 3'b000; ReadData1 = 0; ReadData2 = 0; SignEx = 0;
    rs_addr = 0; In2016 = 0; IN1511 = 0;
    exmem_fwd_regwrite = 0; memwb_fwd_regwrite = 0; exmem_fwd_rd = 0; memwb_fwd_rd = 0;
    exmem_fwd_data = 0; memwb_fwd_data = 0;
  endtask

  // R-type with rs=1, rt=2, rd=9, RegDst=1, RegWrite=1.
  task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    clear();
    ALUOp = 3'b010; SignEx = {26'd0, fn}; ReadData1 = a; ReadData2 = b;
    rs_addr = 5'd1; In2016 = 5'd2; IN1511 = 5'd9; RegDst = 1; RegWrite = 1;
  endtask

  task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
    set_r(6'h18, a, b);
    IN1511 = 5'd4;
  endtask

  task automatic test_reset();
    set_r(6'h20, 32'd5, 32'd7);
    #3;
    total++; if (RegWriteOUT !== 1'b0) $display("FAIL reset_regwrite got %b exp 0", RegWriteOUT); else passed++;
    total++; if (ALUResultOUT !== 32'd0) $display("FAIL reset_result got %h exp 0", ALUResultOUT); else passed++;
    total++; if (DestRegOUT !== 5'd0) $display("FAIL reset_dest got %0d exp 0", DestRegOUT); else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_o); else passed++;
    step(); rst = 0;
  endtask

  task automatic test_alu();
    set_r(6'h20, 32'd5, 32'd7); step();
    total++; if (ALUResultOUT !== 32'd12) $display("FAIL add_result got %h exp 0000000c", ALUResultOUT); else passed++;
    total++; if (DestRegOUT !== 5'd9) $display("FAIL add_dest got %0d exp 9", DestRegOUT); else passed++;
    total++; if (RegWriteOUT !== 1'b1) $display("FAIL add_regwrite got %b exp 1", RegWriteOUT); else passed++;
    total++; if (WriteDataOUT !== 32'd7) $display("FAIL add_wdata got %h exp 00000007", WriteDataOUT); else passed++;

    set_r(6'h2A, 32'hFFFF_FFFF, 32'd1); step();
    total++; if (ALUResultOUT !== 32'd1) $display("FAIL slt_signed got %h exp 00000001", ALUResultOUT); else passed++;
    set_r(6'h2A, 32'd1, 32'hFFFF_FFFF); step();
    total++; if (ALUResultOUT !== 32'd0) $display("FAIL slt_false got %h exp 00000000", ALUResultOUT); else passed++;

    clear(); ALUOp = 3'b000; ReadData1 = 32'hFFFF_FFFF; ReadData2 = 32'd1; RegWrite = 1; In2016 = 5'd6; step();
    total++; if (ALUResultOUT !== 32'd0) $display("FAIL add_wrap got %h exp 00000000", ALUResultOUT); else passed++;
    total++; if (DestRegOUT !== 5'd6) $display("FAIL dest_rt got %0d exp 6", DestRegOUT); else passed++;

    clear(); ALUOp = 3'b110; SignEx = 32'h1234; step();
    total++; if (ALUResultOUT !== 32'h1234_0000) $display("FAIL lui got %h exp 12340000", ALUResultOUT); else passed++;

    set_r(6'h00, 32'd0, 32'd3); SignEx = 32'h0000_0100; step();
    total++; if (ALUResultOUT !== 32'h30) $display("FAIL sll got %h exp 00000030", ALUResultOUT); else passed++;

    clear(); ALUOp = 3'b011; ReadData1 = 32'hF0F0; ReadData2 = 32'hFF00; step();
    total++; if (ALUResultOUT !== 32'hF000) $display("FAIL and got %h exp 0000f000", ALUResultOUT); else passed++;

    clear(); ALUOp = 3'b100; ALUSrc = 1; ReadData1 = 32'h0F00; SignEx = 32'h00F0; step();
    total++; if (ALUResultOUT !== 32'h0FF0) $display("FAIL ori_imm got %h exp 00000ff0", ALUResultOUT); else passed++;

    clear(); ALUOp = 3'b111; ReadData1 = 32'd5; ReadData2 = 32'd5; step();
    total++; if (ALUResultOUT !== 32'd0) $display("FAIL aluop_unlisted got %h exp 00000000", ALUResultOUT); else passed++;

    set_r(6'h3F, 32'd5, 32'd5); step();
    total++; if (ALUResultOUT !== 32'd0) $display("FAIL funct_unlisted got %h exp 00000000", ALUResultOUT); else passed++;
  endtask

  task automatic test_forward();
    set_r(6'h22, 32'h50, 32'd1); rs_addr = 5'd3; In2016 = 5'd7;
    exmem_fwd_regwrite = 1; exmem_fwd_rd = 5'd3; exmem_fwd_data = 32'h10;
    memwb_fwd_regwrite = 1; memwb_fwd_rd = 5'd3; memwb_fwd_data = 32'h20;
    step();
    total++; if (ALUResultOUT !== 32'h0F) $display("FAIL fwd_exmem_prio got %h exp 0000000f", ALUResultOUT); else passed++;

    exmem_fwd_regwrite = 0; step();
    total++; if (ALUResultOUT !== 32'h1F) $display("FAIL fwd_memwb got %h exp 0000001f", ALUResultOUT); else passed++;

    exmem_fwd_regwrite = 1; rs_addr = 5'd0; exmem_fwd_rd = 5'd0; memwb_fwd_rd = 5'd0; step();
    total++; if (ALUResultOUT !== 32'h4F) $display("FAIL fwd_r0 got %h exp 0000004f", ALUResultOUT); else passed++;

    // Store: B forwarded from MEM/WB into store data, ALU uses immediate.
    clear(); ALUOp = 3'b000; ALUSrc = 1; MemWrite = 1; SignEx = 32'd4;
    ReadData1 = 32'h100; ReadData2 = 32'hDEAD; rs_addr = 5'd1; In2016 = 5'd3;
    memwb_fwd_regwrite = 1; memwb_fwd_rd = 5'd3; memwb_fwd_data = 32'h77;
    step();
    total++; if (ALUResultOUT !== 32'h104) $display("FAIL sw_addr got %h exp 00000104", ALUResultOUT); else passed++;
    total++; if (WriteDataOUT !== 32'h77) $display("FAIL sw_fwd_data got %h exp 00000077", WriteDataOUT); else passed++;
    total++; if (MemWriteOUT !== 1'b1) $display("FAIL sw_memwrite got %b exp 1", MemWriteOUT); else passed++;
  endtask

`ifdef EX_MULT_EN
  // Mul already driven; counts stall cycles and non-bubble outputs during them.
  task automatic run_mul(input bit perturb);
    stalls = 0; bad = 0;
    #1;
    while (stall_o && stalls < 60) begin
      step();
      stalls++;
      if (RegWriteOUT | MemToRegOUT | MemReadOUT | MemWriteOUT) bad++;
      if (perturb && stalls == 5) begin
        exmem_fwd_regwrite = 1; exmem_fwd_rd = 5'd1; exmem_fwd_data = 32'd100;
      end
    end
    step();
  endtask

  task automatic test_mul();
    set_mul(32'd6, 32'd7); run_mul(1);
    total++; if (stalls !== 33) $display("FAIL mul_stall_cycles got %0d exp 33", stalls); else passed++;
    total++; if (bad !== 0) $display("FAIL mul_bubbles got %0d non-bubble exp 0", bad); else passed++;
    total++; if (ALUResultOUT !== 32'd42) $display("FAIL mul_result got %h exp 0000002a", ALUResultOUT); else passed++;
    total++; if (RegWriteOUT !== 1'b1) $display("FAIL mul_regwrite got %b exp 1", RegWriteOUT); else passed++;
    total++; if (DestRegOUT !== 5'd4) $display("FAIL mul_dest got %0d exp 4", DestRegOUT); else passed++;
    clear();
  endtask

  task automatic test_back_to_back();
    set_mul(32'h0000_FFFF, 32'h0001_0001); run_mul(0);
    total++; if (stalls !== 33) $display("FAIL b2b1_stall got %0d exp 33", stalls); else passed++;
    total++; if (ALUResultOUT !== 32'hFFFF_FFFF) $display("FAIL b2b1_result got %h exp ffffffff", ALUResultOUT); else passed++;
    set_mul(32'd3, 32'd3); run_mul(0);
    total++; if (stalls !== 33) $display("FAIL b2b2_stall got %0d exp 33", stalls); else passed++;
    total++; if (ALUResultOUT !== 32'd9) $display("FAIL b2b2_result got %h exp 00000009", ALUResultOUT); else passed++;
    clear();
  endtask

  task automatic test_mul_reset();
    set_mul(32'd5, 32'd9);
    for (int i = 0; i < 10; i++) step();
    total++; if (stall_o !== 1'b1) $display("FAIL busy_stall got %b exp 1", stall_o); else passed++;
    rst = 1; #1;
    total++; if (stall_o !== 1'b0) $display("FAIL rst_mid_stall got %b exp 0", stall_o); else passed++;
    total++; if (ALUResultOUT !== 32'd0 || RegWriteOUT !== 1'b0) $display("FAIL rst_mid_outs got %h/%b exp 0/0", ALUResultOUT, RegWriteOUT); else passed++;
    step(); rst = 0;
    run_mul(0);
    total++; if (stalls !== 33) $display("FAIL restart_stall got %0d exp 33", stalls); else passed++;
    total++; if (ALUResultOUT !== 32'd45) $display("FAIL restart_result got %h exp 0000002d", ALUResultOUT); else passed++;
    clear();
  endtask
`else
  task automatic test_no_mul();
    set_mul(32'd6, 32'd7); #1;
    total++; if (stall_o !== 1'b0) $display("FAIL nomul_stall got %b exp 0", stall_o); else passed++;
    step();
    total++; if (ALUResultOUT !== 32'd0) $display("FAIL nomul_result got %h exp 00000000", ALUResultOUT); else passed++;
    total++; if (RegWriteOUT !== 1'b1) $display("FAIL nomul_regwrite got %b exp 1", RegWriteOUT); else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin step(); if (stall_o !== 1'b0) bad++; end
    total++; if (bad !== 0) $display("FAIL nomul_stall_rise got %0d exp 0", bad); else passed++;
    clear();
  endtask
`endif

  initial begin
    clear();
    test_reset();
    test_alu();
    test_forward();
`ifdef EX_MULT_EN
    test_mul();
    test_back_to_back();
    test_mul_reset();
`else
    test_no_mul();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
